// File: rtl/alu_operand_entry_if.sv
// rtl/alu_operand_entry_if.sv - registered operand/opcode bus from operand entry to the ALU
interface alu_operand_entry_if;
    typedef logic [31:0] word_t;
    typedef logic [3:0]  aluop_t;

    word_t  porta;
    word_t  portb;
    aluop_t aluop;
    logic   exec_valid;

    modport master (output porta, output portb, output aluop, output exec_valid);
    modport slave  (input  porta, input  portb, input  aluop, input  exec_valid);
endinterface

// File: rtl/alu_operand_entry.sv
// rtl/alu_operand_entry.sv - debounced pushbutton/switch entry of ALU operands and opcode
module alu_operand_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [3:0]                 key_n,
    input  logic [17:0]                sw,
    output logic [31:0]                preview,
    output logic [1:0]                 state,
    alu_operand_entry_if.master        alu
);
    localparam int NKEYS     = 3;
    localparam int KEY_ENTER = 0;
    localparam int KEY_CLEAR = 1;
    localparam int KEY_SWAP  = 2;
    localparam logic [23:0] CNT_LAST = 24'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        EXEC    = 2'd3
    } state_t;

    state_t             state_q;
    logic [NKEYS-1:0]   sync1;
    logic [NKEYS-1:0]   sync2;
    logic [NKEYS-1:0]   deb;
    logic [NKEYS-1:0]   deb_prev;
    logic [NKEYS-1:0]   press;
    logic [23:0]        cnt [NKEYS];
    logic [31:0]        porta_q;
    logic [31:0]        portb_q;
    logic [3:0]         aluop_q;
    logic               exec_valid_q;

    // key_n[3] is reserved and sw[17] has no function
    logic unused_inputs;
    assign unused_inputs = ^{key_n[3], sw[17]};

    assign preview        = {{15{sw[16]}}, sw[16:0]};
    assign state          = state_q;
    assign alu.porta      = porta_q;
    assign alu.portb      = portb_q;
    assign alu.aluop      = aluop_q;
    assign alu.exec_valid = exec_valid_q;

    // Two-flop synchroniser; resets to the released (high) level
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_n[NKEYS-1:0];
            sync2 <= sync1;
        end
    end

    // Per-key debouncer: a new level is accepted only after DEBOUNCE_CYCLES stable cycles
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            deb <= '1;
            for (int i = 0; i < NKEYS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NKEYS; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 24'd1;
                end
            end
        end
    end

    // One-cycle press pulse on the falling edge of the debounced level
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            deb_prev <= '1;
            press    <= '0;
        end else begin
            deb_prev <= deb;
            press    <= deb_prev & ~deb;
        end
    end

    // Entry state machine: clear beats enter beats swap; losing pulses are dropped
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= LOAD_A;
            exec_valid_q <= 1'b0;
            porta_q      <= '0;
            portb_q      <= '0;
            aluop_q      <= '0;
        end else if (press[KEY_CLEAR]) begin
            state_q      <= LOAD_A;
            exec_valid_q <= 1'b0;
            porta_q      <= '0;
            portb_q      <= '0;
            aluop_q      <= '0;
        end else if (press[KEY_ENTER]) begin
            case (state_q)
                LOAD_A: begin
                    porta_q <= preview;
                    state_q <= LOAD_B;
                end
                LOAD_B: begin
                    portb_q <= preview;
                    state_q <= LOAD_OP;
                end
                LOAD_OP: begin
                    aluop_q      <= sw[3:0];
                    state_q      <= EXEC;
                    exec_valid_q <= 1'b1;
                end
                default: begin
                    state_q      <= LOAD_A;
                    exec_valid_q <= 1'b0;
                end
            endcase
        end else if (press[KEY_SWAP] && state_q == EXEC) begin
            porta_q <= portb_q;
            portb_q <= porta_q;
        end
    end
endmodule

// File: tb/tb_alu_operand_entry.sv
// tb/tb_alu_operand_entry.sv - directed table-driven bench for alu_operand_entry
module tb_alu_operand_entry;
    logic        CLK;
    logic        nRST;
    logic [3:0]  key_n;
    logic [17:0] sw;
    logic [31:0] preview;
    logic [1:0]  state;

    int passed;
    int total;

    alu_operand_entry_if bus ();

    alu_operand_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .key_n   (key_n),
        .sw      (sw),
        .preview (preview),
        .state   (state),
        .alu     (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        int          key;
        logic [17:0] sw;
        logic [1:0]  st;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic press(input int k);
        key_n[k] = 1'b0;
        tick(12);
        key_n[k] = 1'b1;
        tick(12);
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] op);
        @(negedge CLK);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".exec_valid"}, 32'(bus.exec_valid), 32'(st == 2'd3));
        check({tag, ".porta"}, bus.porta, a);
        check({tag, ".portb"}, bus.portb, b);
        check({tag, ".aluop"}, 32'(bus.aluop), 32'(op));
    endtask

    initial begin
        logic early_ok;
        passed = 0;
        total  = 0;

        //           key  sw         st    porta         portb         op
        vecs[0]  = '{0, 18'h00005, 2'd1, 32'h00000005, 32'h00000000, 4'h0};
        vecs[1]  = '{2, 18'h3FFFF, 2'd1, 32'h00000005, 32'h00000000, 4'h0};
        vecs[2]  = '{0, 18'h1FFFF, 2'd2, 32'h00000005, 32'hFFFFFFFF, 4'h0};
        vecs[3]  = '{0, 18'h00003, 2'd3, 32'h00000005, 32'hFFFFFFFF, 4'h3};
        vecs[4]  = '{0, 18'h00007, 2'd0, 32'h00000005, 32'hFFFFFFFF, 4'h3};
        vecs[5]  = '{0, 18'h08000, 2'd1, 32'h00008000, 32'hFFFFFFFF, 4'h3};
        vecs[6]  = '{0, 18'h00009, 2'd2, 32'h00008000, 32'h00000009, 4'h3};
        vecs[7]  = '{0, 18'h0002A, 2'd3, 32'h00008000, 32'h00000009, 4'hA};
        vecs[8]  = '{2, 18'h1FFFF, 2'd3, 32'h00000009, 32'h00008000, 4'hA};
        vecs[9]  = '{2, 18'h00000, 2'd3, 32'h00008000, 32'h00000009, 4'hA};
        vecs[10] = '{0, 18'h10000, 2'd0, 32'h00008000, 32'h00000009, 4'hA};
        vecs[11] = '{0, 18'h00005, 2'd1, 32'h00000005, 32'h00000009, 4'hA};
        vecs[12] = '{0, 18'h00009, 2'd2, 32'h00000005, 32'h00000009, 4'hA};
        vecs[13] = '{0, 18'h0000F, 2'd3, 32'h00000005, 32'h00000009, 4'hF};
        vecs[14] = '{2, 18'h00000, 2'd3, 32'h00000009, 32'h00000005, 4'hF};
        vecs[15] = '{1, 18'h00000, 2'd0, 32'h00000000, 32'h00000000, 4'h0};

        // Reset
        nRST  = 1'b0;
        key_n = 4'hF;
        sw    = 18'h3FFFF;
        tick(3);
        @(negedge CLK);
        check("reset.preview", preview, 32'hFFFFFFFF);
        nRST = 1'b1;
        check_all("reset", 2'd0, 32'h0, 32'h0, 4'h0);
        tick(2);

        // Table-driven entry, swap and clear sequence
        for (int i = 0; i < 16; i++) begin
            sw = vecs[i].sw;
            press(vecs[i].key);
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].a, vecs[i].b, vecs[i].op);
        end

        // Bounce rejection and press latency (state is LOAD_A, all zero)
        @(posedge CLK); #1;
        sw = 18'h00007;
        key_n[0] = 1'b0;
        tick(3);
        key_n[0] = 1'b1;
        tick(1);
        key_n[0] = 1'b0;
        early_ok = 1'b1;
        for (int j = 0; j < 7; j++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (state !== 2'd0) early_ok = 1'b0;
        end
        check("latency.before_edge", 32'(early_ok), 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        check("latency.at_edge_state", 32'(state), 32'd1);
        check("latency.at_edge_porta", bus.porta, 32'h7);
        @(posedge CLK); #1;
        key_n[0] = 1'b1;
        tick(12);

        // Clear and enter pulses in the same cycle while in LOAD_OP
        sw = 18'h00003;
        press(0);
        check_all("prio.pre", 2'd2, 32'h7, 32'h3, 4'h0);
        key_n[0] = 1'b0;
        key_n[1] = 1'b0;
        tick(12);
        key_n[0] = 1'b1;
        key_n[1] = 1'b1;
        tick(12);
        check_all("prio", 2'd0, 32'h0, 32'h0, 4'h0);

        // Reset in LOAD_B while enter is held
        sw = 18'h00001;
        press(0);
        check_all("rst_mid.pre", 2'd1, 32'h1, 32'h0, 4'h0);
        key_n[0] = 1'b0;
        tick(3);
        nRST = 1'b0;
        tick(1);
        nRST = 1'b1;
        check_all("rst_mid", 2'd0, 32'h0, 32'h0, 4'h0);
        early_ok = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (state !== 2'd0) early_ok = 1'b0;
        end
        check("rst_mid.held_not_immediate", 32'(early_ok), 32'd1);
        @(posedge CLK); #1;
        key_n[0] = 1'b1;
        tick(20);
        press(1);
        check_all("rst_mid.clear", 2'd0, 32'h0, 32'h0, 4'h0);
        sw = 18'h00002;
        press(0);
        check_all("rst_mid.fresh", 2'd1, 32'h2, 32'h0, 4'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
